counter_mod: RTL and testbench
==============================

// Module: counter_mod
// PURPOSE
//  Parametrised up/down counter with runtime modulus, variable step, parallel load and three boundary modes.
//  Modes: wrap, saturate, one-shot.
//  General counting primitive for lab datapaths: event/timer counting, display ramps, address sequencing.
//  Adds a terminal-count pulse, a sticky overflow flag and a one-shot hold FSM.
// PARAMETERS
//  WIDTH   8  count, limit and load_val width (>=2)
//  STEP_W  4  step width; step range 0..2^STEP_W-1
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  en         in   1        count enable
//  dir        in   1        1 = up, 0 = down
//  step       in   STEP_W   increment/decrement magnitude
//  limit      in   WIDTH    inclusive upper bound; legal range 0..limit
//  mode       in   2        00 WRAP, 01 SAT, 10 ONESHOT, 11 = WRAP
//  load       in   1        synchronous load strobe
//  load_val   in   WIDTH    load value
//  clr_ovf    in   1        clears ovf
//  count      out  WIDTH    registered count
//  tc         out  1        1-cycle registered pulse on boundary hit/cross
//  ovf        out  1        sticky: set on any boundary cross
//  done       out  1        high while FSM in HOLD
//  at_zero    out  1        comb: count == 0
//  at_max     out  1        comb: count == limit
// BEHAVIOUR
//  Reset (sync, active-high)
//   - count=0, tc=0, ovf=0, state=RUN, done=0.
//  Priority per cycle: rst > load > (en & state==RUN) > hold.
//  Load
//   - count <= min(load_val, limit); state <= RUN; tc <= 0.
//   - ovf unchanged unless clr_ovf.
//   - load with en high: load wins; no step taken.
//  Step evaluation
//   - Taken when en=1, state=RUN, step!=0.
//   - Any other cycle: count holds, tc <= 0.
//  Arithmetic
//   - Computed in WIDTH+2 bits, unsigned; M = limit+1.
//  Up: s = count+step
//   - s <= limit: count <= s.
//   - s == limit: also tc <= 1.
//   - s > limit (overrun), tc <= 1, ovf <= 1, then by mode:
//     - WRAP: count <= s-M; if s-M > limit, count <= 0.
//     - SAT: count <= limit.
//     - ONESHOT: count <= limit; state <= HOLD.
//  Down: d = count-step
//   - count >= step: count <= d.
//   - d == 0: also tc <= 1.
//   - count < step (underrun), tc <= 1, ovf <= 1, then by mode:
//     - WRAP: count <= count+M-step; clamp to 0 if negative.
//     - SAT: count <= 0.
//     - ONESHOT: count <= 0; state <= HOLD.
//  Out-of-range count
//   - count > limit (limit lowered at runtime): next taken step first clamps count to limit, then applies the rules.
//   - That cycle sets neither tc nor ovf unless the rules do.
//  FSM
//   - RUN -> HOLD on a ONESHOT boundary hit or cross.
//   - HOLD -> RUN on load, or on mode != ONESHOT (next cycle).
//   - done = (state==HOLD).
//  ovf
//   - Set-dominant: a cross and clr_ovf in the same cycle leaves ovf=1.
//  Latency
//   - count, tc and done: 1 cycle after inputs.
//   - at_zero/at_max: combinational from registered count.
// STRUCTURE
//  - counter_pkg: typedef enum logic [1:0] mode_t {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD};
//    typedef enum logic {ST_RUN, ST_HOLD} state_t.
//  - Sub-module counter_step_alu: combinational next-count/tc/cross from (count, step, limit, dir, mode).
//  - counter_mod holds the registers and FSM.
// TESTING
//  1. rst, WIDTH=8, limit=9, step=1, dir=1, WRAP, en=1 for 12 cycles
//     -> count 1..9,0,1,2; tc at count=9 and 0; ovf=1 after wrap.
//  2. limit=255, step=3, dir=0, SAT, load 5 then en
//     -> count 2, then 0 with tc=1, ovf=1, holds 0.
//  3. ONESHOT, limit=20, step=7, up from 0
//     -> 7,14,20 with tc, done=1; count stays 20 with en high.
//     Then load 3 -> count=3, done=0.
//  4. load=1 and en=1 same cycle, load_val=200, limit=100 -> count=100, no step.
//  5. count=50, limit changed to 30, up step 1 -> count=30, at_max=1.
//     clr_ovf together with a cross -> ovf stays 1.
//  6. rst asserted mid-HOLD with en=1 -> next cycle count=0, done=0, ovf=0, tc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: boundary modes and hold-FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11   // behaves as wrap
    } mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic is_oneshot(input mode_t m);
        return m == MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/counter_if.sv
// Control/status bundle for counter_mod; master drives controls, slave is the counter.
interface counter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) ();

    logic              en;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic [1:0]        mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              clr_ovf;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              done;
    logic              at_zero;
    logic              at_max;

    modport master (
        output en, dir, step, limit, mode, load, load_val, clr_ovf,
        input  count, tc, ovf, done, at_zero, at_max
    );

    modport slave (
        input  en, dir, step, limit, mode, load, load_val, clr_ovf,
        output count, tc, ovf, done, at_zero, at_max
    );

endinterface

// File: rtl/counter_step_alu.sv
// Combinational next-count evaluation for one taken step, including boundary handling.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  limit_i,
    input  logic              dir_i,
    input  mode_t             mode_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              tc_o,
    output logic              cross_o,
    output logic              hold_o
);

    // Two guard bits so sums and the modulus never overflow.
    localparam int unsigned AW = WIDTH + 2;

    logic [AW-1:0] lim;
    logic [AW-1:0] stp;
    logic [AW-1:0] modulus;
    logic [AW-1:0] base;
    logic [AW-1:0] sum;
    logic [AW-1:0] dif;
    logic [AW-1:0] wrap_up;
    logic [AW-1:0] wrap_dn;

    // Evaluate the step from a base clamped into 0..limit.
    always_comb begin
        lim     = AW'(limit_i);
        stp     = AW'(step_i);
        modulus = lim + AW'(1);
        base    = (count_i > limit_i) ? lim : AW'(count_i);
        sum     = base + stp;
        dif     = base - stp;
        wrap_up = sum - modulus;
        wrap_dn = base + modulus - stp;

        count_o = base[WIDTH-1:0];
        tc_o    = 1'b0;
        cross_o = 1'b0;

        if (dir_i) begin
            if (sum <= lim) begin
                count_o = sum[WIDTH-1:0];
                tc_o    = (sum == lim);
            end else begin
                tc_o    = 1'b1;
                cross_o = 1'b1;
                case (mode_i)
                    MODE_SAT, MODE_ONESHOT: count_o = limit_i;
                    default:                count_o = (wrap_up > lim) ? '0 : wrap_up[WIDTH-1:0];
                endcase
            end
        end else begin
            if (base >= stp) begin
                count_o = dif[WIDTH-1:0];
                tc_o    = (dif == '0);
            end else begin
                tc_o    = 1'b1;
                cross_o = 1'b1;
                case (mode_i)
                    MODE_SAT, MODE_ONESHOT: count_o = '0;
                    // base + M < step means the wrapped value would be negative
                    default: count_o = ((base + modulus) < stp) ? '0 : wrap_dn[WIDTH-1:0];
                endcase
            end
        end

        hold_o = is_oneshot(mode_i) && tc_o;
    end

endmodule

// File: rtl/counter_mod.sv
// Up/down counter with runtime modulus, variable step, load, and wrap/sat/one-shot modes.
module counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    state_t           state_q;

    logic [WIDTH-1:0] alu_count;
    logic             alu_tc;
    logic             alu_cross;
    logic             alu_hold;
    logic [WIDTH-1:0] load_clamped;
    logic             step_taken;
    mode_t            mode;

    assign mode         = mode_t'(bus.mode);
    assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    assign step_taken   = !bus.load && bus.en && (state_q == ST_RUN) && (bus.step != '0);

    counter_step_alu #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_alu (
        .count_i (count_q),
        .step_i  (bus.step),
        .limit_i (bus.limit),
        .dir_i   (bus.dir),
        .mode_i  (mode),
        .count_o (alu_count),
        .tc_o    (alu_tc),
        .cross_o (alu_cross),
        .hold_o  (alu_hold)
    );

    // Count, terminal pulse, sticky overflow and RUN/HOLD state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            // Set wins over clear.
            if (step_taken && alu_cross) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end

            if (bus.load) begin
                count_q <= load_clamped;
                tc_q    <= 1'b0;
                state_q <= ST_RUN;
            end else if (step_taken) begin
                count_q <= alu_count;
                tc_q    <= alu_tc;
                if (alu_hold) begin
                    state_q <= ST_HOLD;
                end
            end else begin
                tc_q <= 1'b0;
                if (state_q == ST_HOLD && !is_oneshot(mode)) begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.ovf     = ovf_q;
    assign bus.done    = (state_q == ST_HOLD);
    assign bus.at_zero = (count_q == '0);
    assign bus.at_max  = (count_q == bus.limit);

endmodule

// File: tb/tb_counter_mod.sv
// Directed self-checking bench for counter_mod.
module tb_counter_mod;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    counter_if #(.WIDTH(8), .STEP_W(4)) bus ();

    counter_mod #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.load    = 1'b0;
        bus.clr_ovf = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.dir      = 1'b1;
        bus.step     = 4'd1;
        bus.limit    = 8'd9;
        bus.mode     = 2'b00;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.clr_ovf  = 1'b0;

        // Reset state
        tick();
        check("rst_count", bus.count, 0);
        check("rst_tc", bus.tc, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_done", bus.done, 0);
        check("rst_at_zero", bus.at_zero, 1);

        // 1: wrap up, limit 9, step 1
        rst    = 1'b0;
        bus.en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("t1_count_%0d", i), bus.count, (i <= 9) ? i : i - 10);
            check($sformatf("t1_tc_%0d", i), bus.tc, (i == 9 || i == 10) ? 1 : 0);
            check($sformatf("t1_ovf_%0d", i), bus.ovf, (i >= 10) ? 1 : 0);
        end

        // 2: saturate down, limit 255, step 3, from 5
        do_reset();
        bus.limit    = 8'd255;
        bus.step     = 4'd3;
        bus.dir      = 1'b0;
        bus.mode     = 2'b01;
        bus.load     = 1'b1;
        bus.load_val = 8'd5;
        tick();
        check("t2_load", bus.count, 5);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        tick();
        check("t2_c1", bus.count, 2);
        check("t2_tc1", bus.tc, 0);
        check("t2_ovf1", bus.ovf, 0);
        tick();
        check("t2_c2", bus.count, 0);
        check("t2_tc2", bus.tc, 1);
        check("t2_ovf2", bus.ovf, 1);
        check("t2_at_zero", bus.at_zero, 1);
        tick();
        check("t2_c3", bus.count, 0);

        // 3: one-shot up, limit 20, step 7
        do_reset();
        bus.mode  = 2'b10;
        bus.limit = 8'd20;
        bus.step  = 4'd7;
        bus.dir   = 1'b1;
        bus.en    = 1'b1;
        tick();
        check("t3_c1", bus.count, 7);
        check("t3_done1", bus.done, 0);
        tick();
        check("t3_c2", bus.count, 14);
        tick();
        check("t3_c3", bus.count, 20);
        check("t3_tc3", bus.tc, 1);
        check("t3_ovf3", bus.ovf, 1);
        check("t3_done3", bus.done, 1);
        check("t3_at_max", bus.at_max, 1);
        tick();
        check("t3_c4", bus.count, 20);
        check("t3_tc4", bus.tc, 0);
        check("t3_done4", bus.done, 1);
        bus.load     = 1'b1;
        bus.load_val = 8'd3;
        tick();
        check("t3_load_c", bus.count, 3);
        check("t3_load_done", bus.done, 0);
        bus.load = 1'b0;

        // 4: load beats enable and is clamped to limit
        bus.mode     = 2'b00;
        bus.limit    = 8'd100;
        bus.step     = 4'd1;
        bus.en       = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 8'd200;
        tick();
        check("t4_count", bus.count, 100);
        check("t4_tc", bus.tc, 0);
        bus.load = 1'b0;

        // 5: limit lowered below count, then ovf set-dominance
        do_reset();
        bus.limit    = 8'd255;
        bus.load     = 1'b1;
        bus.load_val = 8'd50;
        tick();
        check("t5_load", bus.count, 50);
        bus.load  = 1'b0;
        bus.limit = 8'd30;
        bus.mode  = 2'b01;
        bus.dir   = 1'b1;
        bus.step  = 4'd1;
        bus.en    = 1'b1;
        tick();
        check("t5_clamp_c", bus.count, 30);
        check("t5_at_max", bus.at_max, 1);
        check("t5_tc", bus.tc, 1);
        check("t5_ovf", bus.ovf, 1);
        bus.clr_ovf = 1'b1;
        tick();
        check("t5_set_dom_ovf", bus.ovf, 1);
        bus.en = 1'b0;
        tick();
        check("t5_clr_ovf", bus.ovf, 0);
        check("t5_idle_tc", bus.tc, 0);
        bus.clr_ovf  = 1'b0;
        bus.limit    = 8'd255;
        bus.load     = 1'b1;
        tick();
        bus.load  = 1'b0;
        bus.limit = 8'd30;
        bus.dir   = 1'b0;
        bus.en    = 1'b1;
        tick();
        check("t5_down_clamp_c", bus.count, 29);
        check("t5_down_clamp_tc", bus.tc, 0);
        check("t5_down_clamp_ovf", bus.ovf, 0);

        // Wrap down underrun with mode 11: 2 + 10 - 5 = 7
        bus.limit    = 8'd9;
        bus.mode     = 2'b11;
        bus.load     = 1'b1;
        bus.load_val = 8'd2;
        tick();
        bus.load = 1'b0;
        bus.step = 4'd5;
        tick();
        check("wd_count", bus.count, 7);
        check("wd_tc", bus.tc, 1);
        check("wd_ovf", bus.ovf, 1);

        // Wrap up where s-M exceeds limit: 2+15-3 = 14 > 2 -> 0
        bus.limit    = 8'd2;
        bus.mode     = 2'b00;
        bus.dir      = 1'b1;
        bus.step     = 4'd15;
        bus.load     = 1'b1;
        bus.load_val = 8'd2;
        tick();
        bus.load = 1'b0;
        tick();
        check("wu_count", bus.count, 0);
        check("wu_tc", bus.tc, 1);

        // 6: reset during HOLD with enable high
        bus.mode     = 2'b10;
        bus.limit    = 8'd20;
        bus.step     = 4'd7;
        bus.load     = 1'b1;
        bus.load_val = 8'd14;
        tick();
        bus.load = 1'b0;
        tick();
        check("t6_hold_done", bus.done, 1);
        rst = 1'b1;
        tick();
        check("t6_count", bus.count, 0);
        check("t6_done", bus.done, 0);
        check("t6_ovf", bus.ovf, 0);
        check("t6_tc", bus.tc, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
